// File: rtl/mem_resp_pkg.sv
// Shared types and address decoding for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] idx;
        logic        err;
    } decode_t;

    // Word index relative to base, flagged when below base, past the store or misaligned.
    function automatic decode_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
        decode_t d;
        logic [31:0] off;
        off   = addr - base;
        d.idx = off >> 2;
        d.err = (addr < base) || (d.idx >= depth) || (addr[1:0] != 2'b00);
        return d;
    endfunction

endpackage

// File: rtl/mem_resp_tags.sv
// Direct-mapped valid/tag array used only to pick the response latency.
module mem_resp_tags #(
    parameter int LINES = 16,
    parameter int TAG_W = 6,
    localparam int LINE_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] lookup_line,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic              fill_en,
    input  logic [LINE_W-1:0] fill_line,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              flush,
    output logic              hit
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_q [LINES];

    assign hit = valid[lookup_line] && (tag_q[lookup_line] == lookup_tag);

    // Flush beats a simultaneous fill so the invalidation is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_line] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_line] <= fill_tag;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a backing store and hit/miss latency model.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int                    LINES        = 16,
    parameter int                    HIT_LATENCY  = 1,
    parameter int                    MISS_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           ack,
    output logic                           err,
    output logic                           busy,
    input  logic                           flush_tags,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [DATA_WIDTH-1:0]          load_data,
    output logic [31:0]                    hit_count,
    output logic [31:0]                    miss_count
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int LINE_W = $clog2(LINES);
    localparam int TAG_W  = IDX_W - LINE_W;
    localparam int CNT_W  = $clog2(MISS_LATENCY + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      lat_m1;
    decode_t               dec;
    logic                  tag_hit;
    logic                  accept;
    logic                  commit;
    logic                  unused_idx_bits;

    logic                  we_q, err_q, hit_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    assign dec             = decode_addr(32'(addr), 32'(BASE_ADDR), 32'(DEPTH_WORDS));
    assign unused_idx_bits = ^dec.idx[31:IDX_W];

    // The edge that ends RESP may already accept the next request.
    assign accept = req && ((state == IDLE) || (state == RESP));
    assign commit = (state == WAIT) && (cnt == '0);
    assign lat_m1 = (dec.err || tag_hit) ? CNT_W'(HIT_LATENCY - 1) : CNT_W'(MISS_LATENCY - 1);

    mem_resp_tags #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_line (dec.idx[LINE_W-1:0]),
        .lookup_tag  (dec.idx[IDX_W-1:LINE_W]),
        .fill_en     (commit && !err_q && !hit_q),
        .fill_line   (idx_q[LINE_W-1:0]),
        .fill_tag    (idx_q[IDX_W-1:LINE_W]),
        .flush       (flush_tags),
        .hit         (tag_hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = req ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= lat_m1;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // rdata is only non-zero during the RESP cycle.
            if (commit) begin
                rdata_q <= (!we_q && !err_q) ? mem[idx_q] : '0;
                if (!err_q) begin
                    if (hit_q) hit_count  <= hit_count + 32'd1;
                    else       miss_count <= miss_count + 32'd1;
                end
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            err_q   <= dec.err;
            hit_q   <= tag_hit;
            idx_q   <= dec.idx[IDX_W-1:0];
            wdata_q <= wdata;
        end
    end

    // Bus write is ordered last so it wins a same-index backdoor collision.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
        if (commit && we_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state == RESP);
    assign err   = (state == RESP) && err_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int          DEPTH = 1024;
    localparam int          LINES = 16;
    localparam int          HL    = 1;
    localparam int          ML    = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, busy;
    logic        flush_tags = 1'b0, load_en = 1'b0;
    logic [9:0]  load_idx = '0;
    logic [31:0] load_data = '0;
    logic [31:0] hit_count, miss_count;

    mem_responder dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .flush_tags(flush_tags),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: store, tag table and counters as plain arrays.
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [LINES];
    int          m_tag [LINES];
    int unsigned m_hits = 0, m_misses = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          ack_cyc;
        int unsigned hits;
        int unsigned misses;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    endtask

    task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input int acc, output exp_t e);
        bit e_err, hit;
        int idx, line, tg;
        e_err = (a < BASE) || (a[1:0] != 2'b00);
        idx = 0;
        if (!e_err) begin
            if (((a - BASE) >> 2) >= DEPTH) e_err = 1;
            else idx = int'((a - BASE) >> 2);
        end
        line = idx % LINES;
        tg   = idx / LINES;
        hit  = !e_err && m_valid[line] && (m_tag[line] == tg);
        e.rdata = '0;
        if (!e_err) begin
            if (!w) e.rdata = m_mem[idx];
            else    m_mem[idx] = wd;
            if (hit) m_hits++;
            else begin
                m_misses++;
                m_valid[line] = 1;
                m_tag[line]   = tg;
            end
        end
        e.err     = e_err;
        e.ack_cyc = acc + ((e_err || hit) ? HL : ML);
        e.hits    = m_hits;
        e.misses  = m_misses;
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got ack=1 expected no ack (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("err", err, e.err);
                    check("ack_cycle", cyc, e.ack_cyc);
                    check("hit_count", hit_count, e.hits);
                    check("miss_count", miss_count, e.misses);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_idx = 10'(idx); load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        m_mem[idx] = d;
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush_tags = 1'b1;
        @(negedge clk);
        flush_tags = 1'b0;
        model_flush();
    endtask

    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input bit flush_at_fill);
        exp_t e;
        int   acc;
        drain();
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        model_access(w, a, wd, acc, e);
        sb.push_back(e);
        req = 1'b0; we = 1'b0;
        if (flush_at_fill) begin
            while (cyc < acc + ML - 1) @(negedge clk);
            flush_tags = 1'b1;
            @(negedge clk);
            flush_tags = 1'b0;
            model_flush();
        end
        drain();
    endtask

    task automatic held(input logic [31:0] a0, input int n);
        exp_t        e;
        int          acc, k;
        logic [31:0] a;
        a = a0;
        drain();
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            acc = cyc;
            model_access(1'b0, a, '0, acc, e);
            sb.push_back(e);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (ack !== 1'b1 && k < 20);
            a = a + 32'd4;
            addr = a;
            if (i == n - 1 || k >= 20) req = 1'b0;
            if (k >= 20) break;
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int          r;
        model_flush();
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_hits", hit_count, 32'h0);
        check("rst_misses", miss_count, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_idx = 10'(i); load_data = NOP;
            m_mem[i] = NOP;
        end
        @(negedge clk);
        load_en = 1'b0;

        // Miss then hit, write then read.
        load(0, 32'hDEAD_BEEF);
        access(1'b0, 32'h1000, '0, 1'b0);
        access(1'b0, 32'h1000, '0, 1'b0);
        access(1'b1, 32'h1004, 32'h1234_5678, 1'b0);
        access(1'b0, 32'h1004, '0, 1'b0);

        // Address errors.
        access(1'b0, 32'h0FFC, '0, 1'b0);
        access(1'b1, 32'h1002, 32'hFFFF_FFFF, 1'b0);
        access(1'b0, 32'h2000, '0, 1'b0);
        access(1'b1, 32'h3000, 32'hAAAA_AAAA, 1'b0);

        // Same-line conflict, then flush during a fill.
        access(1'b0, 32'h1040, '0, 1'b0);
        access(1'b0, 32'h1000, '0, 1'b0);
        access(1'b0, 32'h1040, '0, 1'b1);
        access(1'b0, 32'h1040, '0, 1'b0);

        // Held request over primed lines.
        for (int i = 0; i < 10; i++) access(1'b0, BASE + 32'(4 * i), '0, 1'b0);
        held(BASE, 10);

        // Reset during WAIT of a write.
        load(2, 32'hCAFE_F00D);
        flush_idle();
        drain();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h1008; wdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check("busy_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_ack", ack, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_err", err, 1'b0);
        check("midrst_hits", hit_count, 32'h0);
        check("midrst_misses", miss_count, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_flush();
        m_hits = 0;
        m_misses = 0;
        access(1'b0, 32'h1008, '0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                flush_idle();
            end else if (r < 12) begin
                drain();
                load(int'($urandom_range(0, 63)), $urandom);
            end else if (r < 20) begin
                case ($urandom_range(0, 3))
                    0:       ra = BASE - 32'd4;
                    1:       ra = BASE + 32'(4 * $urandom_range(0, 63)) + 32'(1 + $urandom_range(0, 2));
                    2:       ra = BASE + 32'(4 * DEPTH);
                    default: ra = 32'h0;
                endcase
                access(1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
            end else begin
                ra = BASE + 32'(4 * $urandom_range(0, 63));
                access(1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
            end
        end

        drain();
        repeat (3) @(negedge clk);
        check("final_idle", busy, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
